// File: rtl/traffic_timing_scheduler.sv
// traffic_timing_scheduler
//   Upstream stage of the traffic-light FSM. Counts vehicle-detect rising
//   edges per direction. On each cycle-start pulse it sizes the green time
//   for the direction being served, then selects the direction for the
//   next cycle.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous, active-high reset
//   car_det_a/b         level vehicle-present flags (synchronous to clk)
//   tr_valid            one-cycle cycle-start pulse from the FSM
//   howmany_count_red   red duration (s) to the FSM
//   howmany_count_green green duration (s) to the FSM
//   traffic_sel         direction for the FSM's next update (0=A, 1=B)
//   sched_valid         one-cycle pulse when new durations/sel are committed
//   cnt_a/cnt_b         live per-direction vehicle counts
//
// Optional feature macro: TRAFFIC_EMPTY_SKIP_EN
//   When defined, the same direction is served again when the other
//   direction has no waiting vehicles and the served one had traffic.
//
// state  | meaning
// IDLE   | wait for tr_valid, capture the served direction
// LATCH  | snapshot and clear the served direction's counter
// CALC   | green = min(BASE_GREEN + snap*GREEN_STEP, MAX_GREEN)
// COMMIT | drive new durations and sel, pulse sched_valid
module traffic_timing_scheduler #(
  parameter int RED_TIME   = 5,
  parameter int BASE_GREEN = 5,
  parameter int GREEN_STEP = 1,
  parameter int MAX_GREEN  = 20,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_det_a,
  input  logic             car_det_b,
  input  logic             tr_valid,
  output logic [4:0]       howmany_count_red,
  output logic [4:0]       howmany_count_green,
  output logic             traffic_sel,
  output logic             sched_valid,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam int SUM_W = CNT_W + 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, LATCH, CALC, COMMIT} state_t;

  state_t           r_state, w_next;
  logic             r_served;
  logic [CNT_W-1:0] r_snap;
  logic [CNT_W-1:0] r_cnt_a, r_cnt_b;
  logic             r_det_a_q, r_det_b_q;
  logic [4:0]       r_green_calc;
  logic [4:0]       r_green, r_red;
  logic             r_sel, r_sched_valid;

  logic             w_edge_a, w_edge_b;
  logic [SUM_W-1:0] w_sum;
  logic [4:0]       w_green_calc;
  logic [CNT_W-1:0] w_other_cnt;
  logic             w_next_sel;

  assign w_edge_a = car_det_a & ~r_det_a_q;
  assign w_edge_b = car_det_b & ~r_det_b_q;

  assign w_sum        = SUM_W'(BASE_GREEN) + SUM_W'(r_snap) * SUM_W'(GREEN_STEP);
  assign w_green_calc = (w_sum > SUM_W'(MAX_GREEN)) ? 5'(MAX_GREEN) : w_sum[4:0];
  assign w_other_cnt  = r_served ? r_cnt_a : r_cnt_b;

`ifdef TRAFFIC_EMPTY_SKIP_EN
  assign w_next_sel = ((w_other_cnt == '0) && (r_snap != '0)) ? r_served : ~r_served;
`else
  assign w_next_sel = ~r_served;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (tr_valid) w_next = LATCH;
      LATCH:   w_next = CALC;
      CALC:    w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_det_a_q <= 1'b0;
      r_det_b_q <= 1'b0;
    end else begin
      r_det_a_q <= car_det_a;
      r_det_b_q <= car_det_b;
    end
  end

  // A detect edge arriving in LATCH belongs to the new window, so the
  // cleared counter loads 1 instead of 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_a <= '0;
    end else if (r_state == LATCH && !r_served) begin
      r_cnt_a <= w_edge_a ? CNT_W'(1) : '0;
    end else if (w_edge_a && r_cnt_a != CNT_MAX) begin
      r_cnt_a <= r_cnt_a + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_b <= '0;
    end else if (r_state == LATCH && r_served) begin
      r_cnt_b <= w_edge_b ? CNT_W'(1) : '0;
    end else if (w_edge_b && r_cnt_b != CNT_MAX) begin
      r_cnt_b <= r_cnt_b + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_served      <= 1'b0;
      r_snap        <= '0;
      r_green_calc  <= 5'(BASE_GREEN);
      r_green       <= 5'(BASE_GREEN);
      r_red         <= 5'(RED_TIME);
      r_sel         <= 1'b0;
      r_sched_valid <= 1'b0;
    end else begin
      r_sched_valid <= 1'b0;
      case (r_state)
        IDLE:   if (tr_valid) r_served <= r_sel;
        LATCH:  r_snap <= r_served ? r_cnt_b : r_cnt_a;
        CALC:   r_green_calc <= w_green_calc;
        COMMIT: begin
          r_green       <= r_green_calc;
          r_red         <= 5'(RED_TIME);
          r_sel         <= w_next_sel;
          r_sched_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign howmany_count_red   = r_red;
  assign howmany_count_green = r_green;
  assign traffic_sel         = r_sel;
  assign sched_valid         = r_sched_valid;
  assign cnt_a               = r_cnt_a;
  assign cnt_b               = r_cnt_b;

endmodule

// File: tb/tb_traffic_timing_scheduler.sv
// Directed bench for traffic_timing_scheduler with default parameters
// (RED 5, BASE_GREEN 5, STEP 1, MAX_GREEN 20, CNT_W 8).
module tb_traffic_timing_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       car_det_a = 1'b0;
  logic       car_det_b = 1'b0;
  logic       tr_valid = 1'b0;
  logic [4:0] howmany_count_red, howmany_count_green;
  logic       traffic_sel, sched_valid;
  logic [7:0] cnt_a, cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  traffic_timing_scheduler dut (
    .clk                 (clk),
    .reset               (reset),
    .car_det_a           (car_det_a),
    .car_det_b           (car_det_b),
    .tr_valid            (tr_valid),
    .howmany_count_red   (howmany_count_red),
    .howmany_count_green (howmany_count_green),
    .traffic_sel         (traffic_sel),
    .sched_valid         (sched_valid),
    .cnt_a               (cnt_a),
    .cnt_b               (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input int n);
    for (int i = 0; i < n; i++) begin
      car_det_a = 1'b1; tick();
      car_det_a = 1'b0; tick();
    end
  endtask

  task automatic pulse_b(input int n);
    for (int i = 0; i < n; i++) begin
      car_det_b = 1'b1; tick();
      car_det_b = 1'b0; tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick();
  endtask

  int exp_sel;

  initial begin
    // reset state
    do_reset();
    check("rst_red",   howmany_count_red, 5);
    check("rst_green", howmany_count_green, 5);
    check("rst_sel",   traffic_sel, 0);
    check("rst_sv",    sched_valid, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_cnt_b", cnt_b, 0);

    // 3 cars on A, 2 on B, serve A
    pulse_a(3);
    pulse_b(2);
    check("cnt_a_3", cnt_a, 3);
    check("cnt_b_2", cnt_b, 2);
    tr_valid = 1'b1; tick();          // edge t
    tr_valid = 1'b0;
    check("t0_sv", sched_valid, 0);
    tick();                           // edge t+1: LATCH done
    check("latch_cnt_a", cnt_a, 0);
    check("latch_cnt_b", cnt_b, 2);
    tick();                           // edge t+2
    check("t2_green_hold", howmany_count_green, 5);
    check("t2_sv", sched_valid, 0);
    tick();                           // edge t+3
    check("a3_green", howmany_count_green, 8);
    check("a3_red",   howmany_count_red, 5);
    check("a3_sel",   traffic_sel, 1);
    check("a3_sv",    sched_valid, 1);
    tick();
    check("a3_sv_drop",   sched_valid, 0);
    check("a3_green_hold", howmany_count_green, 8);

    // 40 cars on B, serve B -> saturate at 20; tr_valid held 2 cycles
    pulse_b(38);
    check("cnt_b_40", cnt_b, 40);
    tr_valid = 1'b1; tick();
    tick();                           // second high cycle lands in LATCH
    tr_valid = 1'b0;
    tick();
    check("b40_sv_early", sched_valid, 0);
    tick();
    check("b40_green", howmany_count_green, 20);
    check("b40_sel",   traffic_sel, 0);
    check("b40_sv",    sched_valid, 1);
    check("b40_cnt_b", cnt_b, 0);
    tick();
    check("b40_sv_drop", sched_valid, 0);
    tick(); tick(); tick();
    check("b40_no_repeat", sched_valid, 0);
    check("b40_green_hold", howmany_count_green, 20);

    // saturation of cnt_a
    pulse_a(300);
    check("cnt_a_sat", cnt_a, 255);

    // held level counts once
    do_reset();
    car_det_a = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    car_det_a = 1'b0; tick();
    check("held_cnt_a", cnt_a, 1);

    // cnt_a=2, cnt_b=0, serve A; edge on A lands in LATCH
    pulse_a(1);
    check("cnt_a_2", cnt_a, 2);
    tr_valid = 1'b1; tick();
    tr_valid = 1'b0;
    car_det_a = 1'b1; tick();         // LATCH edge
    car_det_a = 1'b0;
    check("latch_edge_cnt_a", cnt_a, 1);
    tick(); tick();
    check("skip_green", howmany_count_green, 7);
`ifdef TRAFFIC_EMPTY_SKIP_EN
    exp_sel = 0;
`else
    exp_sel = 1;
`endif
    check("skip_sel", traffic_sel, exp_sel);
    check("skip_sv",  sched_valid, 1);
    tick();

    // reset asserted while in CALC
    tr_valid = 1'b1; tick();          // LATCH
    tr_valid = 1'b0; tick();          // CALC
    #2 reset = 1'b1;
    #1;
    check("mid_rst_green", howmany_count_green, 5);
    check("mid_rst_sel",   traffic_sel, 0);
    check("mid_rst_cnt_a", cnt_a, 0);
    check("mid_rst_cnt_b", cnt_b, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst_no_sv", sched_valid, 0);
    end
    check("mid_rst_green_hold", howmany_count_green, 5);
    check("mid_rst_red", howmany_count_red, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_timing_scheduler.md
Name: traffic_timing_scheduler

Overview:
- Upstream stage of the traffic-light FSM. Supplies the per-cycle red and green durations and the direction select that the FSM samples.
- Counts vehicle-detect events per direction (A/B) from the VGA vision path over each light cycle.
- On the FSM's cycle-start pulse, sizes the green time for the direction now being served, then toggles the direction for the next cycle.

Parameters:
- RED_TIME, 5, red duration in seconds driven on howmany_count_red; legal range 1..31.
- BASE_GREEN, 5, green seconds with zero detected vehicles; legal range 1..31.
- GREEN_STEP, 1, extra green seconds per detected vehicle.
- MAX_GREEN, 20, saturation ceiling for green; legal range BASE_GREEN..31.
- CNT_W, 8, width of the per-direction vehicle counters.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- car_det_a  input  1  level vehicle-present flag, direction A (synchronous to clk)
- car_det_b  input  1  level vehicle-present flag, direction B
- tr_valid  input  1  one-cycle cycle-start pulse from the FSM; the FSM has just latched traffic_sel
- howmany_count_red  output  5  red duration to the FSM
- howmany_count_green  output  5  green duration to the FSM
- traffic_sel  output  1  direction for the FSM's next UPDATE (0=A, 1=B)
- sched_valid  output  1  one-cycle pulse when new durations and sel are committed
- cnt_a  output  CNT_W  live vehicle count, direction A, for display
- cnt_b  output  CNT_W  live vehicle count, direction B

Behaviour:
- Reset values:
  - howmany_count_red=RED_TIME, howmany_count_green=BASE_GREEN
  - traffic_sel=0, sched_valid=0
  - cnt_a=cnt_b=0, edge-detect registers=0, state=IDLE
- Edge detect:
  - car_det_x is registered once.
  - A rising edge (current=1, previous=0) increments cnt_x by 1.
  - cnt_x saturates at 2^CNT_W-1 (no wrap).
  - A held-high level counts once.
- State machine:
  - IDLE: wait for tr_valid. Capture served = traffic_sel (the value the FSM just latched). Go to LATCH.
  - LATCH: snap_cnt = cnt_served; clear cnt_served. The other direction's counter is untouched. Go to CALC.
  - CALC: sum = BASE_GREEN + snap_cnt*GREEN_STEP, computed at width CNT_W+6 with no overflow. green_calc = min(sum, MAX_GREEN). Go to COMMIT.
  - COMMIT: howmany_count_green <= green_calc; howmany_count_red <= RED_TIME; traffic_sel <= ~served; sched_valid=1 for this cycle only. Return to IDLE.
- Latency:
  - tr_valid sampled high at edge t gives new outputs visible after edge t+3.
  - sched_valid is high in the cycle after edge t+3.
  - Outputs hold stable in all other cycles.
  - The FSM's RED phase lasts at least 1 s, so the late update never truncates a phase.
- Simultaneous events:
  - A detect edge on the served direction in the LATCH cycle: counter loads 1, i.e. it counts into the new window and is not lost.
  - A detect edge in any other state increments normally.
  - Edges on both directions in the same cycle each count.
- tr_valid while not IDLE is ignored. A new cycle start cannot occur within 3 clocks.
- Reset asserted mid-sequence returns everything to reset values immediately. A partially computed green is discarded.

Optional Feature:
- Macro: TRAFFIC_EMPTY_SKIP_EN
- Defined: in COMMIT, if cnt of ~served is 0 and snap_cnt is nonzero, traffic_sel <= served. The same direction is served again because the other direction is empty.
- Undefined: traffic_sel always toggles.

Test Plan:
- Reset, no stimulus -> red=5, green=5, traffic_sel=0, sched_valid=0, cnt_a=cnt_b=0.
- 3 rising edges on car_det_a, then tr_valid pulse with traffic_sel=0 -> 3 clocks later green=8, red=5, traffic_sel=1, sched_valid high 1 cycle, cnt_a=0, cnt_b unchanged.
- 40 rising edges on car_det_b, tr_valid with traffic_sel=1 -> green=20 (saturated), traffic_sel=0. 300 edges on car_det_a -> cnt_a holds 255.
- car_det_a held high 100 cycles -> cnt_a=1. Edge on served direction in the LATCH cycle -> cnt of that direction=1 after LATCH, and snap_cnt excludes it.
- Reset asserted in CALC -> all outputs at reset values next cycle; no sched_valid pulse.
- cnt_a=2, cnt_b=0, tr_valid with traffic_sel=0 -> with TRAFFIC_EMPTY_SKIP_EN, traffic_sel stays 0 and green=7; without it, traffic_sel=1 and green=7.
